pc_redirect_ctrl: RTL
=====================

// Module: pc_redirect_ctrl
// PURPOSE
// - Sequences instruction fetch and next-PC selection for the MIPS core. Owns the PC register.
// - Handshakes with instruction memory and hands fetched instructions to the core.
// - Builds branch and jump targets from word-offset fields (offset<<2) on each retire.
// - Sits between imem and the decode/execute stage; all PC redirection goes through it.
// PARAMETERS
// - RESET_VEC  32'h0000_0000  PC loaded on reset
// - EXC_VEC    32'h0000_0180  PC loaded on misaligned redirect target
// PORTS
// - clk          in   1   single clock, rising edge
// - rst_n        in   1   asynchronous, active-low reset
// - imem_req     out  1   fetch request, held until imem_ack
// - imem_addr    out  32  fetch address (= pc), stable while imem_req=1
// - imem_ack     in   1   fetch complete; imem_data valid this cycle
// - imem_data    in   32  fetched instruction word
// - inst_valid   out  1   inst/inst_pc valid, held until core_ready
// - inst         out  32  instruction handed to core
// - inst_pc      out  32  address of inst
// - core_ready   in   1   core accepts inst this cycle (retire)
// - redir_valid  in   1   retiring inst redirects; sampled only on retire
// - redir_type   in   2   00 branch, 01 jump (j/jal), 10 register (jr), 11 reserved=no redirect
// - redir_imm    in   26  branch: [15:0] signed word offset; jump: 26-bit word index
// - redir_reg    in   32  jr target byte address
// - misalign_err out  1   one-cycle pulse: jr target[1:0]!=0
// - retire_cnt   out  32  retired-instruction count, wraps mod 2^32
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, pc=RESET_VEC; imem_req=0, inst_valid=0,
//   inst=0, inst_pc=0, misalign_err=0, retire_cnt=0.
// - FSM: IDLE -> REQ (unconditional, 1 cycle after reset release).
//   REQ: imem_req=1, imem_addr=pc; on imem_ack latch inst<=imem_data, inst_pc<=pc -> HOLD.
//   HOLD: inst_valid=1; on core_ready: retire, update pc, retire_cnt+=1 -> REQ.
// - Fetch latency: ack in cycle N -> inst_valid=1 in cycle N+1. Retire in cycle M -> imem_req in M+1.
// - Next pc on retire (seq = inst_pc+4):
//   no redirect / type 11: seq
//   branch: seq + ({{14{imm[15]}},imm[15:0]} << 2)   (32-bit, wraps)
//   jump:   {seq[31:28], imm[25:0], 2'b00}
//   register: redir_reg if redir_reg[1:0]==0, else EXC_VEC and misalign_err=1 next cycle.
// - redir_* ignored unless inst_valid & core_ready in the same cycle.
// - imem_ack outside REQ is ignored. core_ready outside HOLD is ignored.
// - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 -> 0.
// - Reset mid-fetch drops the outstanding request. imem must tolerate req falling before ack.
// STRUCTURE
// - Shared package cpu_pkg: RESET_VEC/EXC_VEC defaults, REDIR_BR/REDIR_J/REDIR_JR/REDIR_NONE
//   codes, FSM state encoding (IDLE/REQ/HOLD).
// - One sub-module: pc_target_gen (combinational). Inputs: inst_pc, redir_type, redir_imm,
//   redir_reg. Outputs: next_pc, misalign. Contains the sign-extend and <<2 paths.
// - FSM, PC register, output registers and counter stay in this module.
// TESTING
// - Reset release, imem_ack after 3 cycles:
//   -> imem_addr=0x0 held for 3 cycles; inst_valid=1 next cycle with inst_pc=0x0.
// - Sequential retire at pc 0x0 with core_ready=1, no redirect:
//   -> next imem_addr=0x4; retire_cnt=1.
// - Branch at inst_pc=0x100, imm=16'hFFFE -> next pc 0x0FC.
//   Branch at inst_pc=0x100, imm=16'h0003 -> next pc 0x110.
// - Jump at inst_pc=0x4000_0010, imm=26'h0000040 -> next pc 0x4000_0100.
// - jr redir_reg=0x0000_0202 -> misalign_err pulses 1 cycle; imem_addr=0x180.
//   jr redir_reg=0x0000_0200 -> imem_addr=0x200, no pulse.
// - redir_valid=1 while core_ready=0 -> no pc change.
//   rst_n low during REQ -> imem_req=0 immediately; restart at RESET_VEC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch / PC-redirect path: reset vectors,
// redirect type codes and the fetch sequencer state encoding.
package cpu_pkg;

    localparam logic [31:0] CPU_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] CPU_EXC_VEC   = 32'h0000_0180;

    typedef enum logic [1:0] {
        REDIR_BR   = 2'b00,
        REDIR_J    = 2'b01,
        REDIR_JR   = 2'b10,
        REDIR_NONE = 2'b11
    } redir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/pc_target_gen.sv
// Combinational next-PC generator: sequential, PC-relative branch,
// region jump and register-indirect targets for a retiring instruction.
module pc_target_gen
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = CPU_EXC_VEC
) (
    input  logic [31:0] inst_pc,
    input  logic [1:0]  redir_type,
    input  logic [25:0] redir_imm,
    input  logic [31:0] redir_reg,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] seq_pc;
    logic [31:0] br_off;

    assign seq_pc = inst_pc + 32'd4;
    // Word offset sign-extended and scaled to bytes in one concatenation.
    assign br_off = {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};

    always_comb begin
        next_pc  = seq_pc;
        misalign = 1'b0;
        case (redir_type)
            REDIR_BR: next_pc = seq_pc + br_off;
            REDIR_J:  next_pc = {seq_pc[31:28], redir_imm, 2'b00};
            REDIR_JR: begin
                if (redir_reg[1:0] != 2'b00) begin
                    next_pc  = EXC_VEC;
                    misalign = 1'b1;
                end else begin
                    next_pc = redir_reg;
                end
            end
            default:  next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch sequencer and PC owner: requests one instruction at a time from imem,
// holds it for the core, and selects the next PC when the core retires it.
module pc_redirect_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = CPU_RESET_VEC,
    parameter logic [31:0] EXC_VEC   = CPU_EXC_VEC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        core_ready,
    input  logic        redir_valid,
    input  logic [1:0]  redir_type,
    input  logic [25:0] redir_imm,
    input  logic [31:0] redir_reg,
    output logic        misalign_err,
    output logic [31:0] retire_cnt
);

    fetch_state_t state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] cnt_q, cnt_d;

    logic        fetch_done;
    logic        retire;
    logic [1:0]  eff_type;
    logic [31:0] tgt_pc;
    logic        tgt_misalign;

    assign fetch_done = (state_q == ST_REQ) && imem_ack;
    assign retire     = (state_q == ST_HOLD) && core_ready;
    // Redirect fields only matter on the retire cycle; otherwise fall through sequentially.
    assign eff_type   = redir_valid ? redir_type : REDIR_NONE;

    pc_target_gen #(
        .EXC_VEC (EXC_VEC)
    ) u_tgt (
        .inst_pc    (inst_pc_q),
        .redir_type (eff_type),
        .redir_imm  (redir_imm),
        .redir_reg  (redir_reg),
        .next_pc    (tgt_pc),
        .misalign   (tgt_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  if (imem_ack)   state_d = ST_HOLD;
            ST_HOLD: if (core_ready) state_d = ST_REQ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req   = (state_q == ST_REQ);
        inst_valid = (state_q == ST_HOLD);
    end

    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        if (fetch_done) begin
            inst_d    = imem_data;
            inst_pc_d = pc_q;
        end
        if (retire) begin
            pc_d       = tgt_pc;
            cnt_d      = cnt_q + 32'd1;
            misalign_d = tgt_misalign;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VEC;
            inst_q     <= 32'd0;
            inst_pc_q  <= 32'd0;
            misalign_q <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_addr    = pc_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign misalign_err = misalign_q;
    assign retire_cnt   = cnt_q;

endmodule
